// File: rtl/return_addr_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | return_addr_stack : call/return address stack feeding the program counter |
// | Rev 1.0 - initial release                                                 |
// +----------------------------------------------------------------------------+
module return_addr_stack #(
   parameter int CNTR_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  call,
   input  logic                  ret,
   input  logic                  flush,
   input  logic                  err_clr,
   input  logic [CNTR_WIDTH-1:0] pc_in,
   output logic [CNTR_WIDTH-1:0] ret_data,
   output logic                  empty,
   output logic                  full,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [PTR_WIDTH:0] c_DEPTH = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] c_ONE   = (PTR_WIDTH+1)'(1);

   logic [CNTR_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  w_wr_en;
   logic [PTR_WIDTH-1:0]  w_wr_idx;
   logic [PTR_WIDTH-1:0]  w_top_idx;
   logic                  w_empty, w_full;
   logic                  w_ovf_set, w_unf_set;

   assign w_empty   = (count_q == '0);
   assign w_full    = (count_q == c_DEPTH);
   // Only meaningful when the stack is non-empty; every use is guarded.
   assign w_top_idx = count_q[PTR_WIDTH-1:0] - PTR_WIDTH'(1);

   always_comb begin
      count_d   = count_q;
      w_wr_en   = 1'b0;
      w_wr_idx  = count_q[PTR_WIDTH-1:0];
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      if (flush) begin
         count_d = '0;
      end else begin
         case ({call, ret})
            2'b10: begin
               if (!w_full) begin
                  w_wr_en = 1'b1;
                  count_d = count_q + c_ONE;
               end else begin
                  w_ovf_set = 1'b1;
               end
            end
            2'b01: begin
               if (!w_empty) count_d = count_q - c_ONE;
               else          w_unf_set = 1'b1;
            end
            2'b11: begin
               // Tail call replaces the top; from empty it degrades to a push.
               w_wr_en = 1'b1;
               if (!w_empty) begin
                  w_wr_idx = w_top_idx;
               end else begin
                  count_d   = c_ONE;
                  w_unf_set = 1'b1;
               end
            end
            default: ;
         endcase
      end
      overflow_d  = (overflow_q  & ~err_clr) | w_ovf_set;
      underflow_d = (underflow_q & ~err_clr) | w_unf_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         if (w_wr_en) mem_q[w_wr_idx] <= pc_in;
      end
   end

   assign ret_data  = w_empty ? '0 : mem_q[w_top_idx];
   assign empty     = w_empty;
   assign full      = w_full;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
`default_nettype wire
